// File: rtl/adc_scan_seq.sv
// ============================================================================
// adc_scan_seq
// ----------------------------------------------------------------------------
// Channel-scan sequencer for a SAR ADC behind an analog mux. It walks the set
// bits of a snapshot of chan_mask from lowest to highest. For each channel it
// selects the mux, waits settle_cycles+1 cycles, pulses conv_start and waits
// for conv_done. It then stores the result into a per-channel result bank and
// announces it on result_valid/result_chan/result_data. A pass ends with a
// scan_done pulse. In continuous mode the scan restarts until scan_stop.
//
// Optional build macro:
//   ADC_SCAN_AVG_EN - convert each channel 4 times back-to-back (no re-settle)
//                     and store the truncated mean (sum >> 2).
//
// Ports:
//   sys_clk        system clock, rising edge
//   reset_         asynchronous active-low reset
//   scan_start     pulse, begins a scan (IDLE only, chan_mask != 0)
//   scan_stop      pulse, finish the in-flight channel and then stop
//   continuous     1 = restart the scan after every pass
//   chan_mask      channels to convert, bit n = channel n
//   settle_cycles  mux settling delay
//   mux_sel        analog mux select (changes only when entering SETTLE)
//   conv_start     one-cycle start pulse to the SAR core
//   conv_done      one-cycle end-of-conversion pulse from the SAR core
//   conv_data      SAR result, valid with conv_done
//   result_valid   one-cycle pulse, a result has been stored
//   result_chan    channel of the last stored result (held)
//   result_data    last stored result (held)
//   scan_done      one-cycle pulse at the end of a pass
//   busy           high in every state except IDLE
//   timeout_err    sticky conversion timeout, cleared by the next scan start
//   rd_chan        result bank read address
//   rd_data        bank[rd_chan], registered, one cycle latency
// ============================================================================
module adc_scan_seq #(
   parameter int ADC_WIDTH      = 12,
   parameter int NUM_CH         = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      sys_clk,
   input  logic                      reset_,
   input  logic                      scan_start,
   input  logic                      scan_stop,
   input  logic                      continuous,
   input  logic [NUM_CH-1:0]         chan_mask,
   input  logic [7:0]                settle_cycles,
   output logic [$clog2(NUM_CH)-1:0] mux_sel,
   output logic                      conv_start,
   input  logic                      conv_done,
   input  logic [ADC_WIDTH-1:0]      conv_data,
   output logic                      result_valid,
   output logic [$clog2(NUM_CH)-1:0] result_chan,
   output logic [ADC_WIDTH-1:0]      result_data,
   output logic                      scan_done,
   output logic                      busy,
   output logic                      timeout_err,
   input  logic [$clog2(NUM_CH)-1:0] rd_chan,
   output logic [ADC_WIDTH-1:0]      rd_data
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   // The WAIT counter reads k in the (k+1)-th cycle after the conv_start
   // cycle. Abandoning the conversion at k = TIMEOUT_CYCLES-2 makes
   // timeout_err visible exactly TIMEOUT_CYCLES cycles after conv_start.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, STORE, NEXT} state_t;

   state_t               state_reg, state_next;
   logic [NUM_CH-1:0]    mask_reg, mask_next;
   logic [CH_W-1:0]      idx_reg, idx_next;
   logic [7:0]           settle_cnt_reg, settle_cnt_next;
   logic [TMO_W-1:0]     tmo_cnt_reg, tmo_cnt_next;
   logic                 stop_pending_reg, stop_pending_next;
   logic                 timeout_err_reg, timeout_err_next;
   logic [CH_W-1:0]      result_chan_reg, result_chan_next;
   logic [ADC_WIDTH-1:0] result_data_reg, result_data_next;
   logic [ADC_WIDTH-1:0] rd_data_reg;
   logic [ADC_WIDTH-1:0] bank_q [NUM_CH];

   logic                 next_found;
   logic [CH_W-1:0]      next_idx;
   logic                 stop_now;

`ifdef ADC_SCAN_AVG_EN
   logic [ADC_WIDTH+1:0] acc_reg, acc_next, acc_sum;
   logic [1:0]           conv_cnt_reg, conv_cnt_next;

   assign acc_sum = acc_reg + {2'b00, conv_data};
`endif

   function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
      lowest_bit = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = CH_W'(i);
      end
   endfunction

   // Next set snapshot bit strictly above the current channel.
   always_comb begin
      next_found = 1'b0;
      next_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_reg[i] && (i > int'(idx_reg))) begin
            next_found = 1'b1;
            next_idx   = CH_W'(i);
         end
      end
   end

   // A stop arriving in the NEXT cycle itself counts as pending.
   assign stop_now = stop_pending_reg | scan_stop;

   always_comb begin
      state_next        = state_reg;
      mask_next         = mask_reg;
      idx_next          = idx_reg;
      settle_cnt_next   = settle_cnt_reg;
      tmo_cnt_next      = tmo_cnt_reg;
      stop_pending_next = stop_pending_reg;
      timeout_err_next  = timeout_err_reg;
      result_chan_next  = result_chan_reg;
      result_data_next  = result_data_reg;
      conv_start        = 1'b0;
      scan_done         = 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_next          = acc_reg;
      conv_cnt_next     = conv_cnt_reg;
`endif

      if (scan_stop && (state_reg != IDLE)) stop_pending_next = 1'b1;

      case (state_reg)
         IDLE: begin
            // start+stop in the same cycle is treated as a cancelled start
            if (scan_start && !scan_stop && (chan_mask != '0)) begin
               mask_next        = chan_mask;
               idx_next         = lowest_bit(chan_mask);
               settle_cnt_next  = settle_cycles;
               timeout_err_next = 1'b0;
               state_next       = SETTLE;
`ifdef ADC_SCAN_AVG_EN
               acc_next         = '0;
               conv_cnt_next    = '0;
`endif
            end
         end
         SETTLE: begin
            if (settle_cnt_reg == 8'd0) state_next = START;
            else                        settle_cnt_next = settle_cnt_reg - 8'd1;
         end
         START: begin
            conv_start   = 1'b1;
            tmo_cnt_next = '0;
            state_next   = WAIT;
         end
         WAIT: begin
            if (conv_done) begin
`ifdef ADC_SCAN_AVG_EN
               if (conv_cnt_reg == 2'd3) begin
                  result_data_next = acc_sum[ADC_WIDTH+1:2];
                  result_chan_next = idx_reg;
                  acc_next         = '0;
                  conv_cnt_next    = '0;
                  state_next       = STORE;
               end else begin
                  // next conversion of the same channel, mux already settled
                  acc_next      = acc_sum;
                  conv_cnt_next = conv_cnt_reg + 2'd1;
                  state_next    = START;
               end
`else
               result_data_next = conv_data;
               result_chan_next = idx_reg;
               state_next       = STORE;
`endif
            end else if (tmo_cnt_reg == TMO_LAST) begin
               timeout_err_next = 1'b1;
               state_next       = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         STORE: begin
            state_next = NEXT;
         end
         NEXT: begin
            if (next_found && !stop_now) begin
               idx_next        = next_idx;
               settle_cnt_next = settle_cycles;
               state_next      = SETTLE;
            end else begin
               scan_done = 1'b1;
               if (continuous && !stop_now && (chan_mask != '0)) begin
                  mask_next       = chan_mask;
                  idx_next        = lowest_bit(chan_mask);
                  settle_cnt_next = settle_cycles;
                  state_next      = SETTLE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (state_next == IDLE) stop_pending_next = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge reset_) begin
      if (!reset_) begin
         state_reg        <= IDLE;
         mask_reg         <= '0;
         idx_reg          <= '0;
         settle_cnt_reg   <= '0;
         tmo_cnt_reg      <= '0;
         stop_pending_reg <= 1'b0;
         timeout_err_reg  <= 1'b0;
         result_chan_reg  <= '0;
         result_data_reg  <= '0;
`ifdef ADC_SCAN_AVG_EN
         acc_reg          <= '0;
         conv_cnt_reg     <= '0;
`endif
      end else begin
         state_reg        <= state_next;
         mask_reg         <= mask_next;
         idx_reg          <= idx_next;
         settle_cnt_reg   <= settle_cnt_next;
         tmo_cnt_reg      <= tmo_cnt_next;
         stop_pending_reg <= stop_pending_next;
         timeout_err_reg  <= timeout_err_next;
         result_chan_reg  <= result_chan_next;
         result_data_reg  <= result_data_next;
`ifdef ADC_SCAN_AVG_EN
         acc_reg          <= acc_next;
         conv_cnt_reg     <= conv_cnt_next;
`endif
      end
   end

   // Result bank: one resettable entry per channel, written during STORE.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_bank
         logic [ADC_WIDTH-1:0] entry_reg;

         always_ff @(posedge sys_clk or negedge reset_) begin
            if (!reset_)
               entry_reg <= '0;
            else if ((state_reg == STORE) && (idx_reg == CH_W'(gi)))
               entry_reg <= result_data_reg;
         end

         assign bank_q[gi] = entry_reg;
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge reset_) begin
      if (!reset_) rd_data_reg <= '0;
      else         rd_data_reg <= bank_q[rd_chan];
   end

   assign mux_sel      = idx_reg;
   assign busy         = (state_reg != IDLE);
   assign result_valid = (state_reg == STORE);
   assign result_chan  = result_chan_reg;
   assign result_data  = result_data_reg;
   assign timeout_err  = timeout_err_reg;
   assign rd_data      = rd_data_reg;

endmodule

// File: tb/tb_adc_scan_seq.sv
// ============================================================================
// tb_adc_scan_seq
// ----------------------------------------------------------------------------
// Directed self-checking bench for adc_scan_seq. A small SAR model answers
// each conv_start with conv_done two cycles into WAIT, returning 0x100+channel
// (or a fixed 4-value sequence for the averaging build). A negedge monitor
// logs result_valid / scan_done / conv_start events. It also records how many
// cycles separate each mux change from the following conv_start.
// ============================================================================
`timescale 1ns/1ps
module tb_adc_scan_seq;

   localparam int ADC_WIDTH      = 12;
   localparam int NUM_CH         = 4;
   localparam int TIMEOUT_CYCLES = 4096;

   logic                 sys_clk       = 1'b0;
   logic                 reset_        = 1'b0;
   logic                 scan_start    = 1'b0;
   logic                 scan_stop     = 1'b0;
   logic                 continuous    = 1'b0;
   logic [NUM_CH-1:0]    chan_mask     = '0;
   logic [7:0]           settle_cycles = '0;
   logic [1:0]           mux_sel;
   logic                 conv_start;
   logic                 conv_done     = 1'b0;
   logic [ADC_WIDTH-1:0] conv_data     = '0;
   logic                 result_valid;
   logic [1:0]           result_chan;
   logic [ADC_WIDTH-1:0] result_data;
   logic                 scan_done;
   logic                 busy;
   logic                 timeout_err;
   logic [1:0]           rd_chan       = '0;
   logic [ADC_WIDTH-1:0] rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   // monitor bookkeeping
   int   cyc = 0, last_change = 0, sd_cnt = 0, cs_cnt = 0;
   bit   armed = 1'b0, prev_busy = 1'b0;
   logic [1:0] prev_mux = '0;
   int   rv_chan_q[$];
   int   rv_data_q[$];
   int   cs_delay_q[$];

   // SAR model controls
   bit   sar_en = 1'b1;
   bit   sar_avg_mode = 1'b0;
   logic [1:0] sar_k = '0;
   logic [ADC_WIDTH-1:0] avg_vals [4];

   always #5 sys_clk = ~sys_clk;

   adc_scan_seq #(
      .ADC_WIDTH(ADC_WIDTH), .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .sys_clk(sys_clk), .reset_(reset_), .scan_start(scan_start),
      .scan_stop(scan_stop), .continuous(continuous), .chan_mask(chan_mask),
      .settle_cycles(settle_cycles), .mux_sel(mux_sel), .conv_start(conv_start),
      .conv_done(conv_done), .conv_data(conv_data), .result_valid(result_valid),
      .result_chan(result_chan), .result_data(result_data), .scan_done(scan_done),
      .busy(busy), .timeout_err(timeout_err), .rd_chan(rd_chan), .rd_data(rd_data)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_mon();
      rv_chan_q.delete();
      rv_data_q.delete();
      cs_delay_q.delete();
      sd_cnt = 0;
      cs_cnt = 0;
   endtask

   task automatic pulse_start(input logic [NUM_CH-1:0] mask, input logic [7:0] settle);
      chan_mask     = mask;
      settle_cycles = settle;
      scan_start    = 1'b1;
      tick();
      scan_start    = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_conv_start(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (conv_start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // SAR model: conv_done two cycles after the START cycle ends.
   initial begin
      avg_vals[0] = 12'h0FF;
      avg_vals[1] = 12'h100;
      avg_vals[2] = 12'h101;
      avg_vals[3] = 12'h102;
      forever begin
         if (conv_start && sar_en) begin
            logic [1:0] ch;
            ch = mux_sel;
            @(posedge sys_clk);
            @(posedge sys_clk);
            #1;
            conv_done = 1'b1;
            conv_data = sar_avg_mode ? avg_vals[sar_k] : (12'h100 + 12'(ch));
            sar_k     = sar_k + 2'd1;
            tick();
            conv_done = 1'b0;
         end else begin
            tick();
         end
      end
   end

   // Event monitor, samples on the falling edge.
   initial begin
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (busy && (!prev_busy || (mux_sel != prev_mux))) begin
            last_change = cyc;
            armed       = 1'b1;
         end
         if (conv_start) begin
            cs_cnt++;
            if (armed) begin
               cs_delay_q.push_back(cyc - last_change);
               armed = 1'b0;
            end
         end
         if (result_valid) begin
            rv_chan_q.push_back(int'(result_chan));
            rv_data_q.push_back(int'(result_data));
            $display("[%0t] result_valid ch=%0d data=0x%03h", $time, result_chan, result_data);
         end
         if (scan_done) $display("[%0t] scan_done", $time);
         if (scan_done) sd_cnt++;
         prev_busy = busy;
         prev_mux  = mux_sel;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({busy, conv_start, result_valid, scan_done, timeout_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {busy, conv_start, result_valid, scan_done, timeout_err});
      end
      n_checks++;
      if ({mux_sel, result_chan} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_chan: got %b expected 0000", {mux_sel, result_chan});
      end
      n_checks++;
      if ({result_data, rd_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 000000", {result_data, rd_data});
      end
      reset_ = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_single_pass();
      int exp_ch [3] = '{0, 1, 3};
      int exp_d  [3] = '{'h100, 'h101, 'h103};
      int exp_bank [4] = '{'h100, 'h101, 0, 'h103};
      bit ok;
      int n, got, exp_len;
      clear_mon();
      continuous = 1'b0;
      pulse_start(4'b1011, 8'd3);
      wait_idle(500, ok, n);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done: got busy after 500 cycles expected idle");
      end
`ifdef ADC_SCAN_AVG_EN
      exp_len = 3 * (4 + 4 * 3 + 2);
`else
      exp_len = 3 * (4 + 1 + 2 + 1 + 1);
`endif
      n_checks++;
      if (n !== exp_len) begin
         n_fail++;
         $display("FAIL single_length: got %0d cycles expected %0d", n, exp_len);
      end
      n_checks++;
      if (rv_chan_q.size() !== 3) begin
         n_fail++;
         $display("FAIL single_rv_count: got %0d expected 3", rv_chan_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         got = (i < rv_chan_q.size()) ? rv_chan_q[i] : -1;
         if (got !== exp_ch[i]) begin
            n_fail++;
            $display("FAIL single_chan[%0d]: got %0d expected %0d", i, got, exp_ch[i]);
         end
         n_checks++;
         got = (i < rv_data_q.size()) ? rv_data_q[i] : -1;
         if (got !== exp_d[i]) begin
            n_fail++;
            $display("FAIL single_data[%0d]: got %0h expected %0h", i, got, exp_d[i]);
         end
         n_checks++;
         got = (i < cs_delay_q.size()) ? cs_delay_q[i] : -1;
         if (got !== 4) begin
            n_fail++;
            $display("FAIL single_settle[%0d]: got %0d expected 4", i, got);
         end
      end
      n_checks++;
      if (sd_cnt !== 1) begin
         n_fail++;
         $display("FAIL single_scan_done: got %0d expected 1", sd_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         rd_chan = 2'(i);
         tick();
         n_checks++;
         if (int'(rd_data) !== exp_bank[i]) begin
            n_fail++;
            $display("FAIL single_bank[%0d]: got %0h expected %0h", i, rd_data, exp_bank[i]);
         end
      end
   endtask

   task automatic test_continuous_stop();
      bit ok;
      int n, got, guard;
      clear_mon();
      continuous = 1'b1;
      pulse_start(4'b0110, 8'd2);
      guard = 0;
      while ((rv_chan_q.size() < 5) && (guard < 2000)) begin
         tick();
         guard++;
      end
      repeat (3) tick();
      scan_stop = 1'b1;
      tick();
      scan_stop = 1'b0;
      wait_idle(500, ok, n);
      continuous = 1'b0;
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL cont_stop_idle: got busy expected idle after stop");
      end
      n_checks++;
      if (rv_chan_q.size() !== 6) begin
         n_fail++;
         $display("FAIL cont_rv_count: got %0d expected 6", rv_chan_q.size());
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         got = (i < rv_chan_q.size()) ? rv_chan_q[i] : -1;
         if (got !== ((i % 2 == 0) ? 1 : 2)) begin
            n_fail++;
            $display("FAIL cont_chan[%0d]: got %0d expected %0d", i, got, (i % 2 == 0) ? 1 : 2);
         end
      end
      n_checks++;
      got = (rv_data_q.size() == 6) ? rv_data_q[5] : -1;
      if (got !== 'h102) begin
         n_fail++;
         $display("FAIL cont_last_data: got %0h expected 102", got);
      end
      n_checks++;
      if (sd_cnt !== 3) begin
         n_fail++;
         $display("FAIL cont_scan_done: got %0d expected 3", sd_cnt);
      end
      repeat (20) tick();
      n_checks++;
      if ({busy, 32'(rv_chan_q.size())} !== {1'b0, 32'd6}) begin
         n_fail++;
         $display("FAIL cont_stays_idle: got busy=%b rv=%0d expected busy=0 rv=6",
                  busy, rv_chan_q.size());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      clear_mon();
      sar_en = 1'b0;
      pulse_start(4'b0001, 8'd0);
      wait_conv_start(20, ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_conv_start: got none expected conv_start");
      end
      repeat (TIMEOUT_CYCLES - 1) tick();
      n_checks++;
      if ({timeout_err, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL tmo_before: got err=%b busy=%b expected err=0 busy=1", timeout_err, busy);
      end
      tick();
      n_checks++;
      if ({timeout_err, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL tmo_at_limit: got err=%b busy=%b expected err=1 busy=0", timeout_err, busy);
      end
      n_checks++;
      if ({sd_cnt, 32'(rv_chan_q.size())} !== 64'd0) begin
         n_fail++;
         $display("FAIL tmo_no_pulses: got scan_done=%0d rv=%0d expected 0 0", sd_cnt, rv_chan_q.size());
      end
      sar_en = 1'b1;
      pulse_start(4'b0001, 8'd0);
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_clear: got %b expected 0", timeout_err);
      end
      wait_idle(200, ok, n);
      n_checks++;
      if ({ok, 32'(rv_chan_q.size())} !== {1'b1, 32'd1}) begin
         n_fail++;
         $display("FAIL tmo_recover: got ok=%b rv=%0d expected ok=1 rv=1", ok, rv_chan_q.size());
      end
   endtask

   task automatic test_edge_cases();
      bit ok;
      int n, got;
      clear_mon();
      pulse_start(4'b1000, 8'd0);
      n_checks++;
      if ({busy, mux_sel} !== 3'b111) begin
         n_fail++;
         $display("FAIL edge_start: got busy=%b mux=%0d expected busy=1 mux=3", busy, mux_sel);
      end
      tick();
      pulse_start(4'b0001, 8'd5);     // ignored: not IDLE
      wait_idle(200, ok, n);
      n_checks++;
      got = (cs_delay_q.size() > 0) ? cs_delay_q[0] : -1;
      if (got !== 1) begin
         n_fail++;
         $display("FAIL edge_settle0: got %0d cycles expected 1", got);
      end
      n_checks++;
      got = (rv_chan_q.size() == 1) ? rv_chan_q[0] : -1;
      if ({ok, 32'(got), 32'(sd_cnt)} !== {1'b1, 32'd3, 32'd1}) begin
         n_fail++;
         $display("FAIL edge_single: got ok=%b chan=%0d scan_done=%0d expected 1 3 1", ok, got, sd_cnt);
      end
      chan_mask  = 4'b1111;
      scan_start = 1'b1;
      scan_stop  = 1'b1;
      tick();
      scan_start = 1'b0;
      scan_stop  = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL edge_start_stop: got busy=%b expected 0", busy);
      end
      pulse_start(4'b0000, 8'd0);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL edge_zero_mask: got busy=%b expected 0", busy);
      end
      repeat (5) tick();
      n_checks++;
      if ({busy, 32'(rv_chan_q.size())} !== {1'b0, 32'd1}) begin
         n_fail++;
         $display("FAIL edge_stays_idle: got busy=%b rv=%0d expected 0 1", busy, rv_chan_q.size());
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int n, got;
      clear_mon();
      sar_en = 1'b0;
      pulse_start(4'b0010, 8'd1);
      wait_conv_start(20, ok);
      repeat (2) tick();
      reset_ = 1'b0;
      repeat (2) tick();
      n_checks++;
      if ({busy, conv_start, result_valid, scan_done, timeout_err, mux_sel, result_chan} !== 9'b0) begin
         n_fail++;
         $display("FAIL rst_outputs: got %b expected 0",
                  {busy, conv_start, result_valid, scan_done, timeout_err, mux_sel, result_chan});
      end
      n_checks++;
      if ({result_data, rd_data} !== 24'h0) begin
         n_fail++;
         $display("FAIL rst_data: got %h expected 000000", {result_data, rd_data});
      end
      reset_ = 1'b1;
      sar_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_chan = 2'(i);
         tick();
         n_checks++;
         if (rd_data !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_bank[%0d]: got %h expected 000", i, rd_data);
         end
      end
      n_checks++;
      if ({busy, 32'(rv_chan_q.size()), 32'(sd_cnt)} !== 65'd0) begin
         n_fail++;
         $display("FAIL rst_no_pulses: got busy=%b rv=%0d sd=%0d expected 0 0 0",
                  busy, rv_chan_q.size(), sd_cnt);
      end
      pulse_start(4'b0010, 8'd1);
      wait_idle(200, ok, n);
      rd_chan = 2'd1;
      tick();
      n_checks++;
      got = (rv_data_q.size() == 1) ? rv_data_q[0] : -1;
      if ({ok, 32'(got), 32'(sd_cnt), rd_data} !== {1'b1, 32'h101, 32'd1, 12'h101}) begin
         n_fail++;
         $display("FAIL rst_new_scan: got ok=%b data=%0h sd=%0d bank1=%h expected 1 101 1 101",
                  ok, got, sd_cnt, rd_data);
      end
   endtask

`ifdef ADC_SCAN_AVG_EN
   task automatic test_avg();
      bit ok;
      int n, got;
      clear_mon();
      sar_avg_mode = 1'b1;
      sar_k        = 2'd0;
      pulse_start(4'b0100, 8'd1);
      wait_idle(300, ok, n);
      sar_avg_mode = 1'b0;
      n_checks++;
      if ({ok, 32'(rv_chan_q.size()), 32'(cs_cnt), 32'(sd_cnt)} !== {1'b1, 32'd1, 32'd4, 32'd1}) begin
         n_fail++;
         $display("FAIL avg_counts: got ok=%b rv=%0d conv_start=%0d sd=%0d expected 1 1 4 1",
                  ok, rv_chan_q.size(), cs_cnt, sd_cnt);
      end
      n_checks++;
      got = (rv_data_q.size() == 1) ? rv_data_q[0] : -1;
      if (got !== 'h100) begin
         n_fail++;
         $display("FAIL avg_value: got %0h expected 100", got);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pass();
      test_continuous_stop();
      test_timeout();
      test_edge_cases();
      test_reset_mid_wait();
`ifdef ADC_SCAN_AVG_EN
      test_avg();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
